// File: rtl/metaball_pkg.sv
// Shared types and constants for the metaball frame scheduler.
//   fp_t          : signed Q16.15 fixed-point value
//   FP_ONE/FP_MAX : 1.0 and the largest positive Q16.15 value
//   sched_state_e : scheduler FSM states
//   int_to_fp()   : integer pixel coordinate to Q16.15
package metaball_pkg;

    typedef logic signed [31:0] fp_t;

    localparam int          FP_FRAC = 15;
    localparam logic [31:0] FP_ONE  = 32'h0000_8000;
    localparam logic [31:0] FP_MAX  = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACCUM = 3'd3,
        EMIT  = 3'd4,
        MOVE  = 3'd5
    } sched_state_e;

    function automatic fp_t int_to_fp(input logic [31:0] col);
        return fp_t'(col << FP_FRAC);
    endfunction

endpackage

// File: rtl/metaball_sched_raster_ctr.sv
// Raster column/row counter for the metaball scheduler.
//   i_clk, i_rst          : clock, async active-high reset
//   i_adv                 : step one pixel in raster order (wraps to (0,0) after the last)
//   i_clr                 : force position to (0,0); wins over i_adv
//   o_col, o_row          : current position
//   o_nxt_col, o_nxt_row  : position after this cycle (lets the parent register p_x/p_y
//                           in the same cycle the raster moves)
//   o_last                : current position is the last pixel of the frame
module raster_ctr #(
    parameter int H_RES = 64,
    parameter int V_RES = 48,
    localparam int CW = $clog2(H_RES),
    localparam int RW = $clog2(V_RES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_adv,
    input  logic          i_clr,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_nxt_col,
    output logic [RW-1:0] o_nxt_row,
    output logic          o_last
);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_col_wrap;
    logic          w_row_wrap;

    assign w_col_wrap = (r_col == CW'(H_RES - 1));
    assign w_row_wrap = (r_row == RW'(V_RES - 1));
    assign o_last     = w_col_wrap && w_row_wrap;
    assign o_col      = r_col;
    assign o_row      = r_row;

    // Next raster position: clear, advance with line/frame wrap, or hold.
    always_comb begin
        o_nxt_col = r_col;
        o_nxt_row = r_row;
        if (i_clr) begin
            o_nxt_col = '0;
            o_nxt_row = '0;
        end else if (i_adv) begin
            if (w_col_wrap) begin
                o_nxt_col = '0;
                if (w_row_wrap) begin
                    o_nxt_row = '0;
                end else begin
                    o_nxt_row = r_row + 1'b1;
                end
            end else begin
                o_nxt_col = r_col + 1'b1;
                o_nxt_row = r_row;
            end
        end else begin
            o_nxt_col = r_col;
            o_nxt_row = r_row;
        end
    end

    // Position register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= o_nxt_col;
            r_row <= o_nxt_row;
        end
    end

endmodule

// File: rtl/metaball_sched.sv
// Frame-level scheduler for an array of metaball field evaluators.
// Walks the raster, broadcasts Q16.15 pixel coordinates with px_stb, waits for a
// rising ball_vld from every ball (or a timeout), sums the non-negative field values
// one ball per cycle, thresholds the saturated sum and offers the pixel on a
// valid/ready port. After the last pixel of a frame it pulses mov_en once.
//   clk, rst            : clock, async active-high reset
//   run                 : level enable for issuing new pixels
//   ball_vld, ball_out  : per-ball result valid and Q16.15 field value
//   px_stb, p_x, p_y    : evaluation start pulse and the pixel coordinates
//   mov_en              : end-of-frame position step pulse
//   pix_vld/pix_rdy     : output handshake; pix_on/pix_sum/pix_col/pix_row/sof payload
//   err                 : sticky WAIT timeout flag
module metaball_sched import metaball_pkg::*; #(
    parameter int          N_BALLS = 4,
    parameter int          H_RES   = 64,
    parameter int          V_RES   = 48,
    parameter logic [31:0] THRESH  = FP_ONE,
    parameter int          TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [N_BALLS-1:0]         ball_vld,
    input  logic [32*N_BALLS-1:0]      ball_out,
    output logic                       px_stb,
    output logic [31:0]                p_x,
    output logic [31:0]                p_y,
    output logic                       mov_en,
    output logic                       pix_vld,
    input  logic                       pix_rdy,
    output logic                       pix_on,
    output logic [31:0]                pix_sum,
    output logic [$clog2(H_RES)-1:0]   pix_col,
    output logic [$clog2(V_RES)-1:0]   pix_row,
    output logic                       sof,
    output logic                       err
);

    localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
    localparam int AW = 32 + IW;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(H_RES);
    localparam int RW = $clog2(V_RES);

    sched_state_e  r_state;
    sched_state_e  w_next;
    logic [N_BALLS-1:0] r_done;
    logic [N_BALLS-1:0] r_vld_q;
    logic [TW-1:0] r_tmo;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_acc;
    logic          r_px_stb, r_mov_en, r_pix_vld, r_pix_on, r_sof, r_err;
    logic [31:0]   r_p_x, r_p_y, r_pix_sum;
    logic [CW-1:0] r_pix_col;
    logic [RW-1:0] r_pix_row;

    logic [CW-1:0] w_col, w_nxt_col;
    logic [RW-1:0] w_row, w_nxt_row;
    logic          w_last, w_all_done, w_tmo_hit, w_idx_last;
    logic [31:0]   w_ball [N_BALLS];
    logic [31:0]   w_sel, w_add, w_sat;
    logic [AW-1:0] w_acc_nxt;

    raster_ctr #(.H_RES(H_RES), .V_RES(V_RES)) u_raster (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_adv     ((r_state == EMIT) && pix_rdy),
        .i_clr     (r_state == MOVE),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_nxt_col (w_nxt_col),
        .o_nxt_row (w_nxt_row),
        .o_last    (w_last)
    );

    assign w_all_done = &r_done;
    // The counter value plus the current cycle equals the number of WAIT cycles spent.
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
    assign w_idx_last = (r_idx == IW'(N_BALLS - 1));

    // Ball field values: unpack the bus; balls that never finished or went negative add 0.
    always_comb begin
        for (int i = 0; i < N_BALLS; i++) begin
            w_ball[i] = ball_out[32*i +: 32];
        end
        w_sel = w_ball[r_idx];
        if (r_done[r_idx] && !w_sel[31]) begin
            w_add = w_sel;
        end else begin
            w_add = 32'h0000_0000;
        end
        w_acc_nxt = r_acc + AW'(w_add);
        if (w_acc_nxt > AW'(FP_MAX)) begin
            w_sat = FP_MAX;
        end else begin
            w_sat = w_acc_nxt[31:0];
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (run) w_next = ISSUE;
                else     w_next = IDLE;
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (w_all_done || w_tmo_hit) w_next = ACCUM;
                else                         w_next = WAIT;
            end
            ACCUM: begin
                if (w_idx_last) w_next = EMIT;
                else            w_next = ACCUM;
            end
            EMIT: begin
                if (pix_rdy) begin
                    if (w_last)   w_next = MOVE;
                    else if (run) w_next = ISSUE;
                    else          w_next = IDLE;
                end else begin
                    w_next = EMIT;
                end
            end
            MOVE: begin
                if (run) w_next = ISSUE;
                else     w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State, datapath and output registers; strobes are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_done    <= '0;
            r_vld_q   <= '0;
            r_tmo     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_px_stb  <= 1'b0;
            r_mov_en  <= 1'b0;
            r_pix_vld <= 1'b0;
            r_pix_on  <= 1'b0;
            r_sof     <= 1'b0;
            r_err     <= 1'b0;
            r_p_x     <= 32'h0000_0000;
            r_p_y     <= 32'h0000_0000;
            r_pix_sum <= 32'h0000_0000;
            r_pix_col <= '0;
            r_pix_row <= '0;
        end else begin
            r_state   <= w_next;
            r_px_stb  <= (w_next == ISSUE);
            r_mov_en  <= (w_next == MOVE);
            r_pix_vld <= (w_next == EMIT);
            if (w_next == ISSUE) begin
                r_p_x <= int_to_fp(32'(w_nxt_col));
                r_p_y <= int_to_fp(32'(w_nxt_row));
            end
            case (r_state)
                ISSUE: begin
                    r_done  <= '0;
                    r_vld_q <= ball_vld;
                    r_tmo   <= '0;
                    r_acc   <= '0;
                    r_idx   <= '0;
                end
                WAIT: begin
                    // Only a fresh rising edge counts; a level left high from power-up does not.
                    r_vld_q <= ball_vld;
                    r_done  <= r_done | (ball_vld & ~r_vld_q);
                    r_tmo   <= r_tmo + 1'b1;
                    if (!w_all_done && w_tmo_hit) begin
                        r_err <= 1'b1;
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + 1'b1;
                    if (w_idx_last) begin
                        r_pix_sum <= w_sat;
                        r_pix_on  <= (w_sat >= THRESH);
                        r_pix_col <= w_col;
                        r_pix_row <= w_row;
                        r_sof     <= (w_col == '0) && (w_row == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign px_stb  = r_px_stb;
    assign p_x     = r_p_x;
    assign p_y     = r_p_y;
    assign mov_en  = r_mov_en;
    assign pix_vld = r_pix_vld;
    assign pix_on  = r_pix_on;
    assign pix_sum = r_pix_sum;
    assign pix_col = r_pix_col;
    assign pix_row = r_pix_row;
    assign sof     = r_sof;
    assign err     = r_err;

endmodule

// File: tb/tb_metaball_sched.sv
// Directed self-checking bench for metaball_sched (2 balls, 4x2 raster, TIMEOUT=20).
module tb_metaball_sched;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        pix_rdy;
    logic [1:0]  bv = 2'b11;
    logic [31:0] bo [2];
    logic [63:0] bo_bus;
    logic [31:0] val [2];
    logic [1:0]  en = 2'b11;
    logic [1:0]  busy = 2'b00;
    int          cnt [2];

    logic        px_stb, mov_en, pix_vld, pix_on, sof, err;
    logic [31:0] p_x, p_y, pix_sum;
    logic [1:0]  pix_col;
    logic        pix_row;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    assign bo_bus = {bo[1], bo[0]};

    metaball_sched #(
        .N_BALLS (2),
        .H_RES   (4),
        .V_RES   (2),
        .THRESH  (32'h0000_8000),
        .TIMEOUT (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .ball_vld (bv),
        .ball_out (bo_bus),
        .px_stb   (px_stb),
        .p_x      (p_x),
        .p_y      (p_y),
        .mov_en   (mov_en),
        .pix_vld  (pix_vld),
        .pix_rdy  (pix_rdy),
        .pix_on   (pix_on),
        .pix_sum  (pix_sum),
        .pix_col  (pix_col),
        .pix_row  (pix_row),
        .sof      (sof),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural evaluators: vld drops after px_stb and rises LAT cycles after it (if enabled).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (px_stb) begin
                bv[i]   <= 1'b0;
                busy[i] <= 1'b1;
                cnt[i]  <= 1;
            end else if (busy[i]) begin
                if (cnt[i] == LAT - 1) begin
                    if (en[i]) begin
                        bv[i]   <= 1'b1;
                        bo[i]   <= val[i];
                        busy[i] <= 1'b0;
                    end
                end else begin
                    cnt[i] <= cnt[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pixel: wait for px_stb, load ball values, wait for pix_vld, check, hold, handshake.
    task automatic do_pixel(input logic [31:0] v0, input logic [31:0] v1, input logic e1,
                            input int col, input int row, input logic [31:0] esum,
                            input logic eon, input logic eerr, input int hold, output int k);
        k = 0;
        while (px_stb !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("stb_seen", 32'(px_stb), 32'd1);
        val[0] = v0;
        val[1] = v1;
        en[1]  = e1;
        chk("p_x", p_x, 32'(col << 15));
        chk("p_y", p_y, 32'(row << 15));
        chk("mov_en_at_stb", 32'(mov_en), 32'd0);
        chk("vld_at_stb", 32'(pix_vld), 32'd0);
        k = 0;
        while (pix_vld !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("pix_vld", 32'(pix_vld), 32'd1);
        chk("pix_col", 32'(pix_col), 32'(col));
        chk("pix_row", 32'(pix_row), 32'(row));
        chk("sof", 32'(sof), (col == 0 && row == 0) ? 32'd1 : 32'd0);
        chk("pix_sum", pix_sum, esum);
        chk("pix_on", 32'(pix_on), 32'(eon));
        chk("err", 32'(err), 32'(eerr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(pix_vld), 32'd1);
            chk("hold_sum", pix_sum, esum);
            chk("hold_col", 32'(pix_col), 32'(col));
            chk("hold_stb", 32'(px_stb), 32'd0);
        end
        pix_rdy = 1'b1;
        @(negedge clk);
        pix_rdy = 1'b0;
        chk("hs_vld_low", 32'(pix_vld), 32'd0);
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        pix_rdy = 1'b0;
        val[0] = 32'h0; val[1] = 32'h0;
        bo[0] = 32'h0;  bo[1] = 32'h0;
        #12;
        chk("rst_px_stb", 32'(px_stb), 32'd0);
        chk("rst_p_x", p_x, 32'd0);
        chk("rst_pix_vld", 32'(pix_vld), 32'd0);
        chk("rst_mov_en", 32'(mov_en), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;

        // Row 0: latency + 5-cycle backpressure, threshold boundary, saturation.
        do_pixel(32'h0000_4000, 32'h0000_4000, 1'b1, 0, 0, 32'h0000_8000, 1'b1, 1'b0, 5, lat);
        chk("latency", 32'(lat), 32'd9);
        do_pixel(32'h0000_4000, 32'h0000_3FFF, 1'b1, 1, 0, 32'h0000_7FFF, 1'b0, 1'b0, 0, lat);
        do_pixel(32'h7FFF_0000, 32'h7FFF_0000, 1'b1, 2, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, lat);
        do_pixel(32'h0000_4000, 32'h0000_4000, 1'b1, 3, 0, 32'h0000_8000, 1'b1, 1'b0, 0, lat);
        // Row 1: ball 1 times out, then a negative value, then normal pixels; err stays set.
        do_pixel(32'h0000_1234, 32'h0000_5000, 1'b0, 0, 1, 32'h0000_1234, 1'b0, 1'b1, 0, lat);
        do_pixel(32'h0000_9000, 32'h8000_0000, 1'b1, 1, 1, 32'h0000_9000, 1'b1, 1'b1, 0, lat);
        do_pixel(32'h0000_2000, 32'h0000_1000, 1'b1, 2, 1, 32'h0000_3000, 1'b0, 1'b1, 0, lat);
        do_pixel(32'h0000_8000, 32'h0000_0000, 1'b1, 3, 1, 32'h0000_8000, 1'b1, 1'b1, 0, lat);
        // End of frame: one mov_en pulse, then the next frame starts at (0,0).
        chk("mov_en_pulse", 32'(mov_en), 32'd1);
        chk("mov_no_stb", 32'(px_stb), 32'd0);
        @(negedge clk);
        chk("mov_en_once", 32'(mov_en), 32'd0);
        chk("frame2_stb", 32'(px_stb), 32'd1);
        chk("frame2_p_x", p_x, 32'd0);
        chk("frame2_p_y", p_y, 32'd0);

        // Asynchronous reset during WAIT.
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_pix_sum", pix_sum, 32'd0);
        chk("arst_pix_on", 32'(pix_on), 32'd0);
        chk("arst_px_stb", 32'(px_stb), 32'd0);
        chk("arst_pix_vld", 32'(pix_vld), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_pixel(32'h0000_4000, 32'h0000_4000, 1'b1, 0, 0, 32'h0000_8000, 1'b1, 1'b0, 0, lat);
        run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/metaball_sched.md
Name: metaball_sched

Overview:
Frame-level controller for an array of metaball field evaluators. It walks the raster and broadcasts each pixel's Q16.15 coordinates with a px_stb pulse, then waits for every ball to report vld. It sums the field contributions sequentially, thresholds the sum to an on/off pixel and hands the pixel downstream on a valid/ready interface. At end of frame it issues one mov_en pulse so the balls step their positions.

Parameters:
N_BALLS, 4, number of metaball evaluators served (1..16)
H_RES, 64, pixels per line
V_RES, 48, lines per frame
THRESH, 32'h0000_8000, iso-surface threshold in Q16.15 (1.0)
TIMEOUT, 1023, max WAIT cycles before the pixel is force-completed

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
run  in  1  level; enables scheduling of new pixels
ball_vld  in  N_BALLS  per-ball result valid (rises when a division completes)
ball_out  in  32*N_BALLS  per-ball field value, Q16.15, ball i at [32i+31:32i]
px_stb  out  1  one-cycle pulse starting evaluation on all balls
p_x  out  32  pixel column in Q16.15 (col<<15), held through WAIT
p_y  out  32  pixel row in Q16.15 (row<<15), held through WAIT
mov_en  out  1  one-cycle pulse after the last pixel of a frame
pix_vld  out  1  output pixel valid
pix_rdy  in  1  downstream ready
pix_on  out  1  1 when the field sum >= THRESH
pix_sum  out  32  saturated field sum, Q16.15
pix_col  out  $clog2(H_RES)  column of the emitted pixel
pix_row  out  $clog2(V_RES)  row of the emitted pixel
sof  out  1  qualifies pix_vld for pixel (0,0)
err  out  1  sticky; set on any WAIT timeout, cleared only by rst

Behaviour:
- Reset (asynchronous, any state): every output is 0, FSM goes to IDLE, the raster position is (0,0), and done_mask, the accumulator and the timeout counter are cleared.
- IDLE: when run=1, go to ISSUE.
- ISSUE (1 cycle): drive px_stb=1 with p_x/p_y for the current position; clear done_mask; capture vld_q<=ball_vld; go to WAIT.
- WAIT: done_mask[i] sets on a rising edge of ball_vld[i] (vld & ~vld_q). A vld level that is high on entry does not count; the evaluators power up with vld=1.
  - When done_mask is all ones, go to ACCUM.
  - When the timeout counter reaches TIMEOUT, set err and go to ACCUM. Balls that have not completed contribute 0.
- ACCUM (N_BALLS cycles): add one ball per cycle, index 0 first, into an accumulator of width 32+$clog2(N_BALLS).
  - Operands are treated as unsigned magnitudes; a negative ball_out (bit 31 set) contributes 0.
  - At the end, saturate to 32'h7FFF_FFFF, register pix_sum and pix_on=(sum>=THRESH), then go to EMIT.
- EMIT: pix_vld=1 and pix_on/pix_sum/pix_col/pix_row/sof are held stable until a cycle with pix_vld&pix_rdy. On that handshake, advance the raster:
  - col<H_RES-1: col+1.
  - Otherwise col=0, row+1.
  - Last pixel (H_RES-1,V_RES-1): go to MOVE.
  - Otherwise, if run=1 go to ISSUE, else go to IDLE holding the raster position (resume, not restart).
- MOVE (1 cycle): mov_en=1, raster goes to (0,0), then go to ISSUE if run=1, else IDLE.
- px_stb and mov_en are never asserted in the same cycle. mov_en is never asserted while any evaluation is outstanding.
- Pipeline latency per pixel: 1 (ISSUE) + ball latency + N_BALLS (ACCUM) + 1 cycle to pix_vld.
- Dropping run mid-pixel does not abort the pixel; it completes through EMIT.

Decomposition:
- Package metaball_pkg holds:
  - fp_t (logic signed [31:0], Q16.15) and FP_FRAC=15;
  - FP_ONE=32'h0000_8000 and FP_MAX=32'h7FFF_FFFF;
  - the sched_state_e enum (IDLE, ISSUE, WAIT, ACCUM, EMIT, MOVE);
  - a function int_to_fp(col) = col<<FP_FRAC.
- One natural sub-module is raster_ctr: the col/row counter with advance, last, and the wrap flags.

Test Plan:
Use a behavioural ball model per instance: vld starts at 1, drops 1 cycle after px_stb, rises after L cycles with a programmable value. N_BALLS=2, H_RES=4, V_RES=2.
1. Ball values 0x4000+0x4000, L=5 -> pix_sum=0x0000_8000, pix_on=1; pixel (3,0) shows p_x=0x0001_8000, p_y=0; pix_vld first rises 1+5+2+1 cycles after px_stb.
2. Ball values 0x4000+0x3FFF -> pix_sum=0x7FFF, pix_on=0; 0x7FFF_0000+0x7FFF_0000 -> pix_sum=0x7FFF_FFFF, pix_on=1.
3. Full frame with pix_rdy=1 -> 8 pixels in raster order, sof only on (0,0), exactly one mov_en pulse after the (3,1) handshake, next p_x=p_y=0.
4. Hold pix_rdy=0 for 5 cycles in EMIT -> outputs are stable, no px_stb, the raster does not advance, and the handshake occurs on the cycle pix_rdy=1.
5. Ball 1 never raises vld with TIMEOUT=20 -> after 20 WAIT cycles err=1 (sticky), pix_sum equals ball 0 only, and the frame continues.
6. Assert rst during WAIT -> all outputs are 0 immediately (asynchronously); after release with run=1, px_stb carries p_x=p_y=0.
